// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 front-end types, opcodes and PC helpers.
package rv_pkg;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [31:0] NOP_INST  = {12'd0, 5'd0, 3'b000, 5'd0, OP_IMM};

    typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
    } if_id_t;

    localparam if_id_t BUBBLE = '{valid: 1'b0, pc: 32'd0, inst: NOP_INST, pred_taken: 1'b0};

    // Word-aligned address inside a power-of-two memory.
    function automatic logic [31:0] pc_mask(input int unsigned bytes);
        return (bytes - 32'd1) & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_predecoder.sv
// fetch_predecoder: static taken decision (backward branches, JAL) and target for one fetched word.
module fetch_predecoder
    import rv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic        taken,
    output logic [31:0] target
);

    logic        is_branch;
    logic        is_jal;
    logic [31:0] b_imm;
    logic [31:0] j_imm;

    assign is_branch = inst[6:0] == OP_BRANCH;
    assign is_jal    = inst[6:0] == OP_JAL;
    assign b_imm     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign j_imm     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    // A set sign bit on a branch means a backward (loop) branch.
    assign taken     = (is_branch && inst[31]) || is_jal;
    assign target    = pc + (is_jal ? j_imm : b_imm);

endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: RV32 PC owner and IF/ID register with boot hold-off, stall/flush, redirects and zero-word halt.
// Optional static branch prediction under FETCH_STATIC_PREDICT_EN.
module instruction_fetch_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES  = 1024,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] pc_o,
    input  logic [31:0] inst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        trap_valid_i,
    input  logic [31:0] trap_pc_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_inst_o,
    output logic        ifid_pred_taken_o,
    output logic        halted_o
);

    localparam logic [31:0] MASK = pc_mask(IMEM_BYTES);

    fetch_state_t state, state_next;
    logic [3:0]   boot_cnt, boot_next;
    logic [31:0]  pc, pc_next;
    if_id_t       ifid, ifid_next;
    logic         halted;
    logic         pred_taken;
    logic [31:0]  pred_target;

`ifdef FETCH_STATIC_PREDICT_EN
    fetch_predecoder u_predecoder (
        .pc    (pc),
        .inst  (inst_i),
        .taken (pred_taken),
        .target(pred_target)
    );
`else
    assign pred_taken  = 1'b0;
    assign pred_target = 32'd0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BOOT;
            boot_cnt <= 4'd0;
            pc       <= RESET_PC;
            ifid     <= BUBBLE;
            halted   <= 1'b0;
        end else begin
            state    <= state_next;
            boot_cnt <= boot_next;
            pc       <= pc_next;
            ifid     <= ifid_next;
            halted   <= state_next == HALT;
        end
    end

    always_comb begin
        state_next = state;
        boot_next  = boot_cnt;
        pc_next    = pc;
        ifid_next  = ifid;
        if (state == BOOT) begin
            boot_next  = boot_cnt + 4'd1;
            state_next = (boot_next == 4'(BOOT_CYCLES)) ? RUN : BOOT;
            ifid_next  = BUBBLE;
        end else if (trap_valid_i || redirect_valid_i) begin
            pc_next    = (trap_valid_i ? trap_pc_i : redirect_pc_i) & MASK;
            ifid_next  = BUBBLE;
            state_next = RUN;
        end else if (state == HALT) begin
            ifid_next  = BUBBLE;
        end else if (!stall_i) begin
            if (flush_i) begin
                ifid_next = BUBBLE;
            end else if (inst_i == 32'd0) begin
                ifid_next  = BUBBLE;
                state_next = HALT;
            end else begin
                ifid_next = '{valid: 1'b1, pc: pc, inst: inst_i, pred_taken: pred_taken};
                pc_next   = (pred_taken ? pred_target : pc + 32'd4) & MASK;
            end
        end
    end

    assign pc_o              = pc;
    assign ifid_valid_o      = ifid.valid;
    assign ifid_pc_o         = ifid.pc;
    assign ifid_inst_o       = ifid.inst;
    assign ifid_pred_taken_o = ifid.pred_taken;
    assign halted_o          = halted;

endmodule
